// File: rtl/bclmul.sv
// Multi-cycle carry-less multiplier (CLMUL / CLMULH / CLMULR) for the execute stage.
// Each RUN cycle folds P_BPC bits of operand 2 into a 64-bit accumulator.
module bclmul #(
    parameter int unsigned P_BPC = 4
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_start_i,
    input  logic        s_kill_i,
    input  logic [1:0]  s_mode_i,
    input  logic [31:0] s_op1_i,
    input  logic [31:0] s_op2_i,
    output logic        s_busy_o,
    output logic        s_valid_o,
    output logic [31:0] s_result_o
);

    localparam logic [4:0] IdxStep = 5'(P_BPC);
    localparam logic [4:0] IdxLast = 5'(32 - P_BPC);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] result_q, result_d;

    logic [63:0]      base;
    logic [P_BPC-1:0] window;
    logic [63:0]      acc_step;
    logic [31:0]      acc_sel;

    // Partial product for the current window of operand-2 bits.
    always_comb begin
        base     = 64'(op1_q) << idx_q;
        window   = P_BPC'(op2_q >> idx_q);
        acc_step = acc_q;
        for (int unsigned j = 0; j < P_BPC; j++) begin
            if (window[j]) begin
                acc_step = acc_step ^ (base << j);
            end
        end
    end

    always_comb begin
        unique case (mode_q)
            2'b01:   acc_sel = acc_step[63:32];
            2'b10:   acc_sel = acc_step[62:31];
            default: acc_sel = acc_step[31:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        mode_d   = mode_q;
        result_d = result_q;

        if (s_kill_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    state_d = StIdle;
                    if (s_start_i) begin
                        op1_d   = s_op1_i;
                        op2_d   = s_op2_i;
                        mode_d  = s_mode_i;
                        acc_d   = '0;
                        idx_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    acc_d = acc_step;
                    idx_d = idx_q + IdxStep;
                    if (idx_q == IdxLast) begin
                        state_d  = StDone;
                        result_d = acc_sel;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
        if (s_reset_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            idx_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            mode_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            mode_q   <= mode_d;
            result_q <= result_d;
        end
    end

    assign s_busy_o   = (state_q == StRun);
    assign s_valid_o  = (state_q == StDone);
    assign s_result_o = result_q;

endmodule

// File: tb/tb_bclmul.sv
// Bench for bclmul: four instances (P_BPC = 1, 2, 4, 8) checked every cycle against a
// bit-parity reference model, plus directed literal cases, kill, reset and random traffic.
module tb_bclmul;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start [4];
    logic        kill  [4];
    logic [1:0]  mode  [4];
    logic [31:0] op1   [4];
    logic [31:0] op2   [4];
    logic        busy  [4];
    logic        valid [4];
    logic [31:0] result[4];

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bclmul #(
            .P_BPC(1 << g)
        ) u_dut (
            .s_clk_i   (clk),
            .s_reset_i (rst),
            .s_start_i (start[g]),
            .s_kill_i  (kill[g]),
            .s_mode_i  (mode[g]),
            .s_op1_i   (op1[g]),
            .s_op2_i   (op2[g]),
            .s_busy_o  (busy[g]),
            .s_valid_o (valid[g]),
            .s_result_o(result[g])
        );
    end

    function automatic int lat(int k);
        return 32 >> k;
    endfunction

    // Product bit k is the parity of all a[i] & b[k-i] pairs.
    function automatic logic [31:0] clmul_ref(logic [31:0] a, logic [31:0] b, logic [1:0] m);
        logic [63:0] p;
        p = '0;
        for (int k = 0; k < 63; k++) begin
            for (int i = 0; i < 32; i++) begin
                if (k - i >= 0 && k - i < 32) p[k] = p[k] ^ (a[i] & b[k-i]);
            end
        end
        if (m == 2'b01) return p[63:32];
        if (m == 2'b10) return p[62:31];
        return p[31:0];
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [P_BPC=%0d]: got %h, expected %h", name, 1 << k, act, exp);
    endtask

    // Reference model: remaining RUN cycles, expected valid pulse and result per instance.
    int          m_cnt [4] = '{0, 0, 0, 0};
    logic        m_valid[4] = '{0, 0, 0, 0};
    logic [31:0] m_res [4] = '{0, 0, 0, 0};
    logic [31:0] m_pend[4] = '{0, 0, 0, 0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                m_cnt[k]   <= 0;
                m_valid[k] <= 1'b0;
                m_res[k]   <= '0;
            end else if (kill[k]) begin
                m_cnt[k]   <= 0;
                m_valid[k] <= 1'b0;
            end else if (m_cnt[k] > 0) begin
                m_cnt[k]   <= m_cnt[k] - 1;
                m_valid[k] <= (m_cnt[k] == 1);
                if (m_cnt[k] == 1) m_res[k] <= m_pend[k];
            end else begin
                m_valid[k] <= 1'b0;
                if (start[k]) begin
                    m_cnt[k]  <= lat(k);
                    m_pend[k] <= clmul_ref(op1[k], op2[k], mode[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 4; k++) begin
                check("busy", k, {31'b0, busy[k]}, {31'b0, m_cnt[k] > 0});
                check("valid", k, {31'b0, valid[k]}, {31'b0, m_valid[k]});
                check("result", k, result[k], m_res[k]);
            end
        end
    end

    task automatic run_op(int k, logic [31:0] a, logic [31:0] b, logic [1:0] m,
                          logic [31:0] exp, string name);
        int n;
        int nb;
        @(posedge clk); #1;
        op1[k] = a; op2[k] = b; mode[k] = m; start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        // Scrambled inputs during RUN must not disturb the latched operands.
        op1[k] = $urandom; op2[k] = $urandom; mode[k] = 2'($urandom_range(0, 3));
        n = 0;
        nb = 0;
        while (valid[k] !== 1'b1 && n < 200) begin
            if (busy[k] === 1'b1) nb++;
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, k, n, lat(k));
        check({name, " busy cycles"}, k, nb, lat(k));
        check({name, " result"}, k, result[k], exp);
    endtask

    task automatic wait_no_valid(int k, int cycles, string name);
        int v;
        v = 0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (valid[k] === 1'b1) v++;
        end
        check(name, k, v, 0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0; kill[k] = 1'b0; mode[k] = '0; op1[k] = '0; op2[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        for (int k = 0; k < 4; k++) check("reset result", k, result[k], 32'h0);

        // Directed literal cases on every P_BPC.
        for (int k = 0; k < 4; k++) begin
            run_op(k, 32'h00000003, 32'h00000003, 2'b00, 32'h00000005, "clmul 3x3");
            run_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h55555555, "clmul ones");
            run_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h55555555, "clmulh ones");
            run_op(k, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 32'hAAAAAAAA, "clmulr ones");
            run_op(k, 32'h80000000, 32'h00000002, 2'b00, 32'h00000000, "clmul msb");
            run_op(k, 32'h80000000, 32'h00000002, 2'b01, 32'h00000001, "clmulh msb");
            run_op(k, 32'h80000000, 32'h00000002, 2'b10, 32'h00000002, "clmulr msb");
            run_op(k, 32'h00000000, 32'h00000000, 2'b00, 32'h00000000, "clmul zero");
            run_op(k, 32'h00000003, 32'h00000003, 2'b11, 32'h00000005, "mode 11");
        end

        // Back-to-back on P_BPC=4, with ignored start pulses during RUN.
        @(posedge clk); #1;
        op1[2] = 32'h3; op2[2] = 32'h3; mode[2] = 2'b00; start[2] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (valid[2] !== 1'b1 && n < 200) begin
            start[2] = 1'b1; op1[2] = $urandom; op2[2] = $urandom;
            @(posedge clk); #1;
            n++;
        end
        check("b2b first latency", 2, n, 8);
        check("b2b first result", 2, result[2], 32'h00000005);
        op1[2] = 32'h80000000; op2[2] = 32'h2; mode[2] = 2'b01; start[2] = 1'b1;
        @(posedge clk); #1;
        start[2] = 1'b0;
        n = 0;
        while (valid[2] !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b second latency", 2, n, 8);
        check("b2b second result", 2, result[2], 32'h00000001);

        // Kill in the 4th RUN cycle: no valid, previous result (5) retained.
        @(posedge clk); #1;
        op1[1] = 32'hFFFFFFFF; op2[1] = 32'hFFFFFFFF; mode[1] = 2'b10; start[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        kill[1] = 1'b1;
        @(posedge clk); #1;
        kill[1] = 1'b0;
        check("kill busy", 1, {31'b0, busy[1]}, 32'h0);
        wait_no_valid(1, 24, "kill no valid");
        check("kill keeps result", 1, result[1], 32'h00000005);

        // Kill and start together: start dropped.
        @(posedge clk); #1;
        start[1] = 1'b1; kill[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0; kill[1] = 1'b0;
        check("kill+start busy", 1, {31'b0, busy[1]}, 32'h0);
        wait_no_valid(1, 20, "kill+start no valid");

        // Asynchronous reset mid-RUN on all instances.
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            op1[k] = 32'h3; op2[k] = 32'h3; mode[k] = 2'b00; start[k] = 1'b1;
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) start[k] = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("async reset busy", k, {31'b0, busy[k]}, 32'h0);
            check("async reset valid", k, {31'b0, valid[k]}, 32'h0);
            check("async reset result", k, result[k], 32'h0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        wait_no_valid(0, 40, "reset aborts op");

        // Random traffic on all instances, checked cycle by cycle by the model.
        repeat (1500) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                start[k] = ($urandom_range(0, 3) == 0);
                kill[k]  = ($urandom_range(0, 24) == 0);
                op1[k]   = $urandom;
                op2[k]   = $urandom;
                mode[k]  = 2'($urandom_range(0, 3));
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            start[k] = 1'b0; kill[k] = 1'b0;
        end
        repeat (40) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
